// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: shared state encoding and staging address map
package motor_pwm_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;
  localparam logic [2:0] ADDR_PERIOD   = 3'd0;
  localparam logic [2:0] ADDR_DEADBAND = 3'd1;
  localparam logic [2:0] ADDR_DUTY0    = 3'd2;
endpackage

// File: rtl/motor_pwm_timebase_if.sv
// motor_pwm_timebase_if: control, staging-write and status signals of the PWM timebase
interface motor_pwm_timebase_if #(
  parameter int SIZE   = 16,
  parameter int PHASES = 3
);
  logic                   iENABLE;
  logic                   iFAULT;
  logic                   iFAULT_CLR;
  logic                   iWR_VALID;
  logic [2:0]             iWR_ADDR;
  logic [SIZE-1:0]        iWR_DATA;
  logic                   iCOMMIT;
  logic                   oWR_READY;
  logic [SIZE-1:0]        oCOUNTER;
  logic [SIZE-1:0]        oPERIOD;
  logic [SIZE-1:0]        oDEADBAND;
  logic [PHASES*SIZE-1:0] oDUTY;
  logic                   oPHASE_ENABLE;
  logic                   oSYNC;
  logic                   oCOMMIT_PENDING;
  logic                   oCOMMIT_DONE;
  logic                   oFAULT_LATCHED;
  modport master (
    output iENABLE, iFAULT, iFAULT_CLR, iWR_VALID, iWR_ADDR, iWR_DATA, iCOMMIT,
    input  oWR_READY, oCOUNTER, oPERIOD, oDEADBAND, oDUTY, oPHASE_ENABLE, oSYNC,
           oCOMMIT_PENDING, oCOMMIT_DONE, oFAULT_LATCHED
  );
  modport slave (
    input  iENABLE, iFAULT, iFAULT_CLR, iWR_VALID, iWR_ADDR, iWR_DATA, iCOMMIT,
    output oWR_READY, oCOUNTER, oPERIOD, oDEADBAND, oDUTY, oPHASE_ENABLE, oSYNC,
           oCOMMIT_PENDING, oCOMMIT_DONE, oFAULT_LATCHED
  );
endinterface

// File: rtl/motor_pwm_shadow.sv
// motor_pwm_shadow: staging/active double buffer, clamping duty and deadband to the new period on apply
module motor_pwm_shadow
  import motor_pwm_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int PHASES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [SIZE-1:0]        wr_data,
  input  logic                   apply,
  output logic [SIZE-1:0]        period,
  output logic [SIZE-1:0]        deadband,
  output logic [PHASES*SIZE-1:0] duty
);
  logic [SIZE-1:0] stg_period;
  logic [SIZE-1:0] stg_deadband;
  logic [SIZE-1:0] stg_duty [PHASES];
  logic [SIZE-1:0] half;
  assign half = stg_period >> 1;
  // staging capture of accepted writes; unknown addresses fall through untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_period   <= '0;
      stg_deadband <= '0;
      for (int i = 0; i < PHASES; i++) stg_duty[i] <= '0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_PERIOD) stg_period <= wr_data;
      if (wr_addr == ADDR_DEADBAND) stg_deadband <= wr_data;
      for (int i = 0; i < PHASES; i++)
        if (wr_addr == ADDR_DUTY0 + 3'(i)) stg_duty[i] <= wr_data;
    end
  end
  // active copy, clamped against the incoming period so outputs never exceed it
  always_ff @(posedge clk) begin
    if (rst) begin
      period   <= '0;
      deadband <= '0;
      duty     <= '0;
    end else if (apply) begin
      period   <= stg_period;
      deadband <= (stg_deadband < half) ? stg_deadband : half;
      for (int i = 0; i < PHASES; i++)
        duty[i*SIZE +: SIZE] <= (stg_duty[i] < stg_period) ? stg_duty[i] : stg_period;
    end
  end
endmodule

// File: rtl/motor_pwm_timebase.sv
// motor_pwm_timebase: IDLE/RUN/FAULT timebase counter with boundary-synchronous parameter commit
module motor_pwm_timebase
  import motor_pwm_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int PHASES = 3
) (
  input logic iCLK,
  input logic iRESET,
  motor_pwm_timebase_if.slave bus
);
  state_t          state;
  logic [SIZE-1:0] counter;
  logic [SIZE-1:0] period;
  logic            phase_en;
  logic            sync;
  logic            pending;
  logic            done;
  logic            fault;
  logic            ready;
  logic            run_ok;
  logic            wrap;
  logic            apply;
  logic            pend_next;
  logic            wr_en;
  assign run_ok    = period >= SIZE'(2);
  assign wrap      = counter >= period - SIZE'(1);
  assign apply     = pending && !bus.iFAULT &&
                     (state == ST_IDLE || (state == ST_RUN && bus.iENABLE && run_ok && wrap));
  assign pend_next = !apply && (pending || bus.iCOMMIT);
  assign wr_en     = bus.iWR_VALID && ready;
  motor_pwm_shadow #(.SIZE(SIZE), .PHASES(PHASES)) u_shadow (
    .clk(iCLK),
    .rst(iRESET),
    .wr_en(wr_en),
    .wr_addr(bus.iWR_ADDR),
    .wr_data(bus.iWR_DATA),
    .apply(apply),
    .period(period),
    .deadband(bus.oDEADBAND),
    .duty(bus.oDUTY)
  );
  assign bus.oPERIOD         = period;
  assign bus.oCOUNTER        = counter;
  assign bus.oPHASE_ENABLE   = phase_en;
  assign bus.oSYNC           = sync;
  assign bus.oCOMMIT_PENDING = pending;
  assign bus.oCOMMIT_DONE    = done;
  assign bus.oFAULT_LATCHED  = fault;
  assign bus.oWR_READY       = ready;
  // state machine, counter and registered status; fault overrides every other event
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= ST_IDLE;
      counter  <= '0;
      phase_en <= 1'b0;
      sync     <= 1'b0;
      pending  <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      ready    <= 1'b1;
    end else begin
      pending <= pend_next;
      ready   <= !pend_next;
      done    <= apply;
      if (bus.iFAULT) begin
        state    <= ST_FAULT;
        counter  <= '0;
        phase_en <= 1'b0;
        sync     <= 1'b0;
        fault    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            counter  <= '0;
            state    <= (bus.iENABLE && run_ok) ? ST_RUN : ST_IDLE;
            phase_en <= bus.iENABLE && run_ok;
            sync     <= bus.iENABLE && run_ok;
          end
          ST_RUN: begin
            if (!bus.iENABLE || !run_ok) begin
              state    <= ST_IDLE;
              counter  <= '0;
              phase_en <= 1'b0;
              sync     <= 1'b0;
            end else begin
              counter  <= wrap ? '0 : counter + SIZE'(1);
              sync     <= wrap;
              phase_en <= 1'b1;
            end
          end
          ST_FAULT: begin
            counter  <= '0;
            phase_en <= 1'b0;
            sync     <= 1'b0;
            if (bus.iFAULT_CLR) begin
              state <= ST_IDLE;
              fault <= 1'b0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            counter  <= '0;
            phase_en <= 1'b0;
            sync     <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_motor_pwm_timebase.sv
// tb_motor_pwm_timebase: directed scenario checks of the PWM timebase
module tb_motor_pwm_timebase;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  motor_pwm_timebase_if #(.SIZE(16), .PHASES(3)) bus ();
  motor_pwm_timebase #(.SIZE(16), .PHASES(3)) dut (.iCLK(clk), .iRESET(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    bus.iWR_VALID = 1'b1;
    bus.iWR_ADDR  = addr;
    bus.iWR_DATA  = data;
    step();
    bus.iWR_VALID = 1'b0;
  endtask
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic test_reset();
    chk("reset_counter", bus.oCOUNTER, 16'd0);
    chk("reset_period", bus.oPERIOD, 16'd0);
    chk("reset_deadband", bus.oDEADBAND, 16'd0);
    chk("reset_duty0", bus.oDUTY[15:0], 16'd0);
    chk("reset_phase_en", 16'(bus.oPHASE_ENABLE), 16'd0);
    chk("reset_sync", 16'(bus.oSYNC), 16'd0);
    chk("reset_pending", 16'(bus.oCOMMIT_PENDING), 16'd0);
    chk("reset_done", 16'(bus.oCOMMIT_DONE), 16'd0);
    chk("reset_fault", 16'(bus.oFAULT_LATCHED), 16'd0);
    chk("reset_ready", 16'(bus.oWR_READY), 16'd1);
  endtask
  task automatic test_basic_run();
    int exp;
    wr(3'd0, 16'd10);
    wr(3'd2, 16'd4);
    wr(3'd1, 16'd2);
    bus.iCOMMIT = 1'b1;
    step();
    bus.iCOMMIT = 1'b0;
    chk("idle_commit_pending", 16'(bus.oCOMMIT_PENDING), 16'd1);
    chk("idle_commit_ready_low", 16'(bus.oWR_READY), 16'd0);
    step();
    chk("idle_commit_done", 16'(bus.oCOMMIT_DONE), 16'd1);
    chk("idle_commit_period", bus.oPERIOD, 16'd10);
    chk("idle_commit_duty0", bus.oDUTY[15:0], 16'd4);
    chk("idle_commit_deadband", bus.oDEADBAND, 16'd2);
    chk("idle_commit_cleared", 16'(bus.oCOMMIT_PENDING), 16'd0);
    step();
    chk("idle_done_pulse_end", 16'(bus.oCOMMIT_DONE), 16'd0);
    chk("idle_phase_en", 16'(bus.oPHASE_ENABLE), 16'd0);
    bus.iENABLE = 1'b1;
    step();
    chk("run_first_counter", bus.oCOUNTER, 16'd0);
    chk("run_first_sync", 16'(bus.oSYNC), 16'd1);
    chk("run_phase_en", 16'(bus.oPHASE_ENABLE), 16'd1);
    exp = 0;
    for (int i = 1; i < 25; i++) begin
      step();
      exp = (exp + 1) % 10;
      chk("run_counter", bus.oCOUNTER, 16'(exp));
      chk("run_sync", 16'(bus.oSYNC), 16'(exp == 0));
    end
  endtask
  task automatic test_commit_in_run();
    for (int k = 0; k < 40 && bus.oCOUNTER !== 16'd3; k++) step();
    chk("wait_count3", bus.oCOUNTER, 16'd3);
    bus.iWR_VALID = 1'b1;
    bus.iWR_ADDR  = 3'd0;
    bus.iWR_DATA  = 16'd20;
    bus.iCOMMIT   = 1'b1;
    step();
    bus.iWR_VALID = 1'b0;
    bus.iCOMMIT   = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      chk("pend_counter", bus.oCOUNTER, 16'(c));
      chk("pend_flag", 16'(bus.oCOMMIT_PENDING), 16'd1);
      chk("pend_ready_low", 16'(bus.oWR_READY), 16'd0);
      chk("pend_old_period", bus.oPERIOD, 16'd10);
      if (c < 9) step();
    end
    step();
    chk("wrap_counter", bus.oCOUNTER, 16'd0);
    chk("wrap_new_period", bus.oPERIOD, 16'd20);
    chk("wrap_done", 16'(bus.oCOMMIT_DONE), 16'd1);
    chk("wrap_pending_clr", 16'(bus.oCOMMIT_PENDING), 16'd0);
    chk("wrap_ready", 16'(bus.oWR_READY), 16'd1);
    chk("wrap_sync", 16'(bus.oSYNC), 16'd1);
    step();
    chk("wrap_done_end", 16'(bus.oCOMMIT_DONE), 16'd0);
    step(18);
    chk("p20_top", bus.oCOUNTER, 16'd19);
    step();
    chk("p20_wrap", bus.oCOUNTER, 16'd0);
  endtask
  task automatic test_clamp();
    wr(3'd0, 16'd16);
    wr(3'd2, 16'd30);
    wr(3'd1, 16'd9);
    wr(3'd4, 16'd7);
    wr(3'd7, 16'd99);
    bus.iCOMMIT = 1'b1;
    step();
    bus.iCOMMIT = 1'b0;
    for (int k = 0; k < 40 && bus.oCOMMIT_DONE !== 1'b1; k++) step();
    chk("clamp_done", 16'(bus.oCOMMIT_DONE), 16'd1);
    chk("clamp_counter", bus.oCOUNTER, 16'd0);
    chk("clamp_period", bus.oPERIOD, 16'd16);
    chk("clamp_duty0", bus.oDUTY[15:0], 16'd16);
    chk("clamp_deadband", bus.oDEADBAND, 16'd8);
    chk("clamp_duty1", bus.oDUTY[31:16], 16'd0);
    chk("clamp_duty2", bus.oDUTY[47:32], 16'd7);
  endtask
  task automatic test_fault();
    for (int k = 0; k < 40 && bus.oCOUNTER !== 16'd5; k++) step();
    chk("wait_count5", bus.oCOUNTER, 16'd5);
    bus.iFAULT = 1'b1;
    step();
    chk("fault_counter", bus.oCOUNTER, 16'd0);
    chk("fault_phase_en", 16'(bus.oPHASE_ENABLE), 16'd0);
    chk("fault_latched", 16'(bus.oFAULT_LATCHED), 16'd1);
    bus.iFAULT_CLR = 1'b1;
    step();
    chk("fault_clr_blocked", 16'(bus.oFAULT_LATCHED), 16'd1);
    chk("fault_hold_counter", bus.oCOUNTER, 16'd0);
    bus.iFAULT = 1'b0;
    step();
    chk("fault_cleared", 16'(bus.oFAULT_LATCHED), 16'd0);
    chk("fault_idle_phase", 16'(bus.oPHASE_ENABLE), 16'd0);
    bus.iFAULT_CLR = 1'b0;
    step();
    chk("restart_phase", 16'(bus.oPHASE_ENABLE), 16'd1);
    chk("restart_sync", 16'(bus.oSYNC), 16'd1);
    step();
    chk("restart_counter", bus.oCOUNTER, 16'd1);
  endtask
  task automatic test_period_one();
    bus.iENABLE = 1'b0;
    step();
    chk("disable_counter", bus.oCOUNTER, 16'd0);
    chk("disable_phase", 16'(bus.oPHASE_ENABLE), 16'd0);
    wr(3'd0, 16'd1);
    bus.iCOMMIT = 1'b1;
    step();
    bus.iCOMMIT = 1'b0;
    step();
    chk("p1_period", bus.oPERIOD, 16'd1);
    chk("p1_duty_clamp", bus.oDUTY[15:0], 16'd1);
    chk("p1_deadband_clamp", bus.oDEADBAND, 16'd0);
    bus.iENABLE = 1'b1;
    step(3);
    chk("p1_phase", 16'(bus.oPHASE_ENABLE), 16'd0);
    chk("p1_counter", bus.oCOUNTER, 16'd0);
    chk("p1_sync", 16'(bus.oSYNC), 16'd0);
  endtask
  task automatic test_reset_mid_run();
    bus.iENABLE = 1'b0;
    wr(3'd0, 16'd10);
    bus.iCOMMIT = 1'b1;
    step();
    bus.iCOMMIT = 1'b0;
    step();
    bus.iENABLE = 1'b1;
    step(4);
    chk("rr_counter_pre", bus.oCOUNTER, 16'd3);
    bus.iWR_VALID = 1'b1;
    bus.iWR_ADDR  = 3'd0;
    bus.iWR_DATA  = 16'd12;
    bus.iCOMMIT   = 1'b1;
    step();
    bus.iWR_VALID = 1'b0;
    bus.iCOMMIT   = 1'b0;
    chk("rr_pending", 16'(bus.oCOMMIT_PENDING), 16'd1);
    rst = 1'b1;
    step();
    chk("rr_counter", bus.oCOUNTER, 16'd0);
    chk("rr_period", bus.oPERIOD, 16'd0);
    chk("rr_duty0", bus.oDUTY[15:0], 16'd0);
    chk("rr_phase", 16'(bus.oPHASE_ENABLE), 16'd0);
    chk("rr_sync", 16'(bus.oSYNC), 16'd0);
    chk("rr_pending_clr", 16'(bus.oCOMMIT_PENDING), 16'd0);
    chk("rr_done", 16'(bus.oCOMMIT_DONE), 16'd0);
    chk("rr_fault", 16'(bus.oFAULT_LATCHED), 16'd0);
    chk("rr_ready", 16'(bus.oWR_READY), 16'd1);
    rst = 1'b0;
    step();
    chk("rr_stay_idle", 16'(bus.oPHASE_ENABLE), 16'd0);
    bus.iENABLE = 1'b0;
  endtask
  initial begin
    bus.iENABLE    = 1'b0;
    bus.iFAULT     = 1'b0;
    bus.iFAULT_CLR = 1'b0;
    bus.iWR_VALID  = 1'b0;
    bus.iWR_ADDR   = 3'd0;
    bus.iWR_DATA   = 16'd0;
    bus.iCOMMIT    = 1'b0;
    step(2);
    test_reset();
    rst = 1'b0;
    step();
    test_basic_run();
    test_commit_in_run();
    test_clamp();
    test_fault();
    test_period_one();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motor_pwm_timebase.md
MOTOR_PWM_TIMEBASE -- requirements
Module: motor_pwm_timebase

Interface
REQ-001 Parameter SIZE, default 16, width of counter, period, duty and deadband words.
REQ-002 Parameter PHASES, default 3, number of duty channels.
REQ-003 iCLK  in  1  single clock; all logic on its rising edge.
REQ-004 iRESET  in  1  reset, synchronous, active-high.
REQ-005 iENABLE  in  1  run request.
REQ-006 iFAULT  in  1  fault input, level-sensitive.
REQ-007 iFAULT_CLR  in  1  fault-clear request.
REQ-008 iWR_VALID  in  1  staging write request.
REQ-009 iWR_ADDR  in  3  staging address: 0=period, 1=deadband, 2..PHASES+1=duty[n-2]; other addresses are discarded.
REQ-010 iWR_DATA  in  SIZE  staging write data.
REQ-011 iCOMMIT  in  1  request that staging be copied to active at the next period boundary.
REQ-012 oWR_READY  out  1  staging write accept.
REQ-013 oCOUNTER  out  SIZE  timebase count, drives every phase stage's iCOUNTER.
REQ-014 oPERIOD, oDEADBAND  out  SIZE each  active values.
REQ-015 oDUTY  out  PHASES*SIZE  active duties; phase n is bits [n*SIZE +: SIZE].
REQ-016 oPHASE_ENABLE  out  1  drives every phase stage's iENABLE.
REQ-017 oSYNC  out  1  one-cycle pulse, high while oCOUNTER==0 in RUN.
REQ-018 oCOMMIT_PENDING, oCOMMIT_DONE, oFAULT_LATCHED  out  1 each  commit status, commit completion pulse, fault state flag.

Function
REQ-019 The block SHALL implement states IDLE, RUN and FAULT; all outputs SHALL be registered.
REQ-020 IDLE: counter held at 0, oPHASE_ENABLE=0; iENABLE=1 with active period>=2 -> RUN.
REQ-021 RUN: counter increments each cycle and wraps from active period-1 to 0; oPHASE_ENABLE=1; iENABLE=0 -> IDLE, with the counter 0 on the next cycle.
REQ-022 If active period<2 in RUN, the block SHALL return to IDLE.
REQ-023 iFAULT=1 in any state SHALL force FAULT on the next cycle: counter 0, oPHASE_ENABLE=0, oFAULT_LATCHED=1.
REQ-024 FAULT -> IDLE only when iFAULT_CLR=1 and iFAULT=0 in the same cycle; a fault takes priority over every other event.
REQ-025 A write SHALL be accepted when iWR_VALID && oWR_READY; the staging register SHALL update on the next cycle.
REQ-026 oWR_READY SHALL be 0 while oCOMMIT_PENDING=1 and 1 otherwise.
REQ-027 iCOMMIT SHALL set oCOMMIT_PENDING; a write accepted in the same cycle SHALL be included in that commit; iCOMMIT while pending SHALL be ignored.
REQ-028 In RUN, a pending commit SHALL be applied on the wrap cycle, so new active values appear together with oCOUNTER==0; this cycle also pulses oCOMMIT_DONE and clears pending.
REQ-029 In IDLE, a pending commit SHALL be applied on the next cycle; in FAULT it SHALL stay pending until IDLE.
REQ-030 At commit, each duty SHALL be clamped to min(duty, period).
REQ-031 At commit, deadband SHALL be clamped to min(deadband, period>>1).
REQ-032 The wrap compare SHALL use the active period before commit; the new period takes effect from count 0.

Reset
REQ-033 iRESET SHALL force these values:
- state IDLE;
- counter, active and staging registers 0;
- oPHASE_ENABLE, oSYNC, oCOMMIT_PENDING, oCOMMIT_DONE, oFAULT_LATCHED 0;
- oWR_READY 1.
REQ-034 Reset SHALL override every other input, including during a pending commit or FAULT.

Structure
REQ-035 The state encoding and the address constants (ADDR_PERIOD, ADDR_DEADBAND, ADDR_DUTY0) SHALL live in a shared package motor_pwm_pkg.
REQ-036 The staging/active double buffer with clamping SHALL be a sub-module motor_pwm_shadow; counter and FSM stay in the top.

Verification
REQ-037 Program period=10, duty0=4, commit, enable -> counter 0..9 repeats; oSYNC at each 0; oDUTY[0]=4.
REQ-038 Write period=20 and commit in RUN at count 3 -> pending until count 9; count 0 with period 20; oCOMMIT_DONE pulse; oWR_READY low in between.
REQ-039 Duty=30, deadband=9 with period=16, commit -> active duty 16, deadband 8.
REQ-040 iFAULT at count 5 -> next cycle counter 0, oPHASE_ENABLE 0, FAULT. iFAULT_CLR with iFAULT=1 -> stays FAULT. Then iFAULT=0 with iFAULT_CLR=1 -> IDLE.
REQ-041 Enable with active period=1 -> state stays IDLE, counter 0, oPHASE_ENABLE 0.
REQ-042 iRESET asserted mid-RUN with a commit pending -> next cycle all outputs at their REQ-033 values, oWR_READY 1.
